// File: rtl/mnist_nn_hex_display_pio.sv
// Avalon-MM hex display PIO: packed nibble-per-digit DATA, per-digit blank/blink masks,
// programmable blink half-period timer and registered active-low 7-segment decode.
module mnist_nn_hex_display_pio #(
  parameter int NUM_DIGITS   = 6,
  parameter int PERIOD_W     = 26,
  parameter int RESET_PERIOD = 25000000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [2:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [4*NUM_DIGITS-1:0] out_port,
  output logic [7*NUM_DIGITS-1:0] seg_n
);

  localparam int DATA_W = 4 * NUM_DIGITS;
  localparam int SEG_W  = 7 * NUM_DIGITS;

  logic [DATA_W-1:0]     data_q, data_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic [NUM_DIGITS-1:0] blink_q, blink_d;
  logic [PERIOD_W-1:0]   period_q, period_d;
  logic [PERIOD_W-1:0]   cnt_q, cnt_d;
  logic                  phase_q, phase_d;
  logic [SEG_W-1:0]      seg_n_q, seg_n_d;

  logic wr;
  logic wr_data, wr_blank, wr_blink, wr_period;
  logic unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wr_data   = wr & (address == 3'd0);
  assign wr_blank  = wr & (address == 3'd1);
  assign wr_blink  = wr & (address == 3'd2);
  assign wr_period = wr & (address == 3'd3);
  assign unused_wd = ^writedata;

  function automatic logic [6:0] hex_to_seg_n(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Register file next-state; writes truncate to register width
  always_comb begin
    data_d   = data_q;
    blank_d  = blank_q;
    blink_d  = blink_q;
    period_d = period_q;
    if (wr_data)   data_d   = writedata[DATA_W-1:0];
    if (wr_blank)  blank_d  = writedata[NUM_DIGITS-1:0];
    if (wr_blink)  blink_d  = writedata[NUM_DIGITS-1:0];
    if (wr_period) period_d = writedata[PERIOD_W-1:0];
  end

  // Blink timer: a PERIOD write restarts the on-phase and beats a same-cycle wrap
  always_comb begin
    cnt_d   = cnt_q + PERIOD_W'(1);
    phase_d = phase_q;
    if (wr_period || (period_q == '0)) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == period_q - PERIOD_W'(1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_comb begin
    seg_n_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!blank_q[i] && (!blink_q[i] || phase_q))
        seg_n_d[7*i +: 7] = hex_to_seg_n(data_q[4*i +: 4]);
    end
  end

  // Stage boundary: register state and decoded segments
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= '0;
      blank_q  <= '0;
      blink_q  <= '0;
      period_q <= PERIOD_W'(RESET_PERIOD);
      cnt_q    <= '0;
      phase_q  <= 1'b1;
      seg_n_q  <= '1;
    end else begin
      data_q   <= data_d;
      blank_q  <= blank_d;
      blink_q  <= blink_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      seg_n_q  <= seg_n_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      3'd0:    readdata[DATA_W-1:0]     = data_q;
      3'd1:    readdata[NUM_DIGITS-1:0] = blank_q;
      3'd2:    readdata[NUM_DIGITS-1:0] = blink_q;
      3'd3:    readdata[PERIOD_W-1:0]   = period_q;
      3'd4:    readdata[0]              = phase_q;
      default: readdata = '0;
    endcase
  end

  assign out_port = data_q;
  assign seg_n    = seg_n_q;

endmodule

// File: tb/tb_mnist_nn_hex_display_pio.sv
// Bench for mnist_nn_hex_display_pio: register vector table with a segment scoreboard,
// plus hand-written reset, blink, period-rewrite and same-cycle sequences.
module tb_mnist_nn_hex_display_pio;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [23:0] out_port;
  logic [41:0] seg_n;

  int tests = 0;
  int fails = 0;

  mnist_nn_hex_display_pio dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .seg_n      (seg_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  localparam logic [6:0] DEC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [23:0] exp_out;
  } vec_t;

  vec_t        vecs [10];
  logic [41:0] sb_q [$];
  logic [23:0] m_data;
  logic [5:0]  m_blank;
  logic [5:0]  m_blink;

  function automatic logic [41:0] model_seg(logic [23:0] d, logic [5:0] bl, logic [5:0] bk, logic ph);
    logic [41:0] r;
    r = '1;
    for (int i = 0; i < 6; i++)
      if (!bl[i] && (!bk[i] || ph)) r[7*i +: 7] = DEC[d[4*i +: 4]];
    return r;
  endfunction

  function automatic logic phase_at(int k, int p);
    return ((k / p) % 2) == 0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name);
    logic [41:0] e;
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: got empty scoreboard expected an entry", name);
    end else begin
      e = sb_q.pop_front();
      check(name, 64'(seg_n), 64'(e));
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] r;
    bus_read(a, r);
    check(name, 64'(r), 64'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r;
    logic        found;

    vecs[0] = '{3'd0, 32'h00FEDCBA, 32'h00FEDCBA, 24'hFEDCBA};
    vecs[1] = '{3'd0, 32'h00543210, 32'h00543210, 24'h543210};
    vecs[2] = '{3'd0, 32'h00000098, 32'h00000098, 24'h000098};
    vecs[3] = '{3'd0, 32'hFFFFFFFF, 32'h00FFFFFF, 24'hFFFFFF};
    vecs[4] = '{3'd1, 32'hFFFFFFC5, 32'h00000005, 24'hFFFFFF};
    vecs[5] = '{3'd2, 32'h0000003A, 32'h0000003A, 24'hFFFFFF};
    vecs[6] = '{3'd1, 32'h00000000, 32'h00000000, 24'hFFFFFF};
    vecs[7] = '{3'd2, 32'h00000000, 32'h00000000, 24'hFFFFFF};
    vecs[8] = '{3'd6, 32'h12345678, 32'h00000000, 24'hFFFFFF};
    vecs[9] = '{3'd7, 32'hFFFFFFFF, 32'h00000000, 24'hFFFFFF};

    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;

    #22;
    check("rst_seg", 64'(seg_n), 64'(42'h3FFFFFFFFFF));
    check("rst_out", 64'(out_port), 64'h0);
    read_check("rst_status", 3'd4, 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("rst_release_seg", 64'(seg_n), 64'(model_seg(24'h0, 6'h0, 6'h0, 1'b1)));
    read_check("rst_period", 3'd3, 32'd25000000);
    read_check("rst_data", 3'd0, 32'h0);

    // Reset asserted in the middle of blinking
    bus_write(3'd2, 32'h3F);
    bus_write(3'd0, 32'h123456);
    bus_write(3'd3, 32'd3);
    repeat (4) @(posedge clk);
    #1;
    read_check("midblink_status", 3'd4, 32'h0);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_seg", 64'(seg_n), 64'(42'h3FFFFFFFFFF));
    check("midrst_out", 64'(out_port), 64'h0);
    read_check("midrst_status", 3'd4, 32'h1);
    read_check("midrst_blink", 3'd2, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("midrst_release_seg", 64'(seg_n), 64'(model_seg(24'h0, 6'h0, 6'h0, 1'b1)));

    // Register table with blink disabled
    bus_write(3'd3, 32'd0);
    m_data  = '0;
    m_blank = '0;
    m_blink = '0;
    for (int i = 0; i < 10; i++) begin
      bus_write(vecs[i].addr, vecs[i].wdata);
      case (vecs[i].addr)
        3'd0: m_data  = vecs[i].exp_rd[23:0];
        3'd1: m_blank = vecs[i].exp_rd[5:0];
        3'd2: m_blink = vecs[i].exp_rd[5:0];
        default: ;
      endcase
      sb_q.push_back(model_seg(m_data, m_blank, m_blink, 1'b1));
      read_check($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].exp_rd);
      check($sformatf("vec%0d_out", i), 64'(out_port), 64'(vecs[i].exp_out));
      tick();
      sb_check($sformatf("vec%0d_seg", i));
    end
    read_check("unused_rd5", 3'd5, 32'h0);
    read_check("after_unused_data", 3'd0, 32'h00FFFFFF);
    read_check("after_unused_period", 3'd3, 32'h0);
    read_check("after_unused_blank", 3'd1, 32'h0);

    // Blink with PERIOD=4 on digit 0
    bus_write(3'd0, 32'h8);
    bus_write(3'd1, 32'h0);
    bus_write(3'd2, 32'h1);
    bus_write(3'd3, 32'd4);
    for (int k = 1; k <= 16; k++) begin
      sb_q.push_back(model_seg(24'h8, 6'h0, 6'h1, phase_at(k - 1, 4)));
      tick();
      sb_check($sformatf("blink_seg_k%0d", k));
      read_check($sformatf("blink_status_k%0d", k), 3'd4, {31'h0, phase_at(k, 4)});
    end
    bus_write(3'd1, 32'h1);
    tick();
    for (int k = 0; k < 8; k++) begin
      sb_q.push_back(model_seg(24'h8, 6'h1, 6'h1, 1'b1));
      tick();
      sb_check($sformatf("blank_over_blink_k%0d", k));
    end
    bus_write(3'd1, 32'h0);

    // PERIOD rewrite right after entering the off-phase
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      bus_read(3'd4, r);
      if (r[0]) found = 1'b1;
      else tick();
    end
    check("wait_on_phase", 64'(found), 64'h1);
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      tick();
      bus_read(3'd4, r);
      if (!r[0]) found = 1'b1;
    end
    check("wait_off_phase", 64'(found), 64'h1);
    bus_write(3'd3, 32'd3);
    read_check("rewrite_status", 3'd4, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      read_check($sformatf("rewrite_status_k%0d", k), 3'd4, {31'h0, phase_at(k, 3)});
    end
    bus_write(3'd3, 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      read_check($sformatf("period0_status_k%0d", k), 3'd4, 32'h1);
    end

    // PERIOD write on the wrap edge
    bus_write(3'd0, 32'h11);
    bus_write(3'd2, 32'h2);
    bus_write(3'd1, 32'h0);
    bus_write(3'd3, 32'd4);
    repeat (3) @(posedge clk);
    bus_write(3'd3, 32'd4);
    read_check("wrap_write_status", 3'd4, 32'h1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      read_check($sformatf("wrap_status_k%0d", k), 3'd4, {31'h0, (k < 4)});
    end

    // DATA write on the same edge the phase drops to off
    repeat (7) @(posedge clk);
    bus_write(3'd0, 32'h37);
    read_check("same_edge_status", 3'd4, 32'h0);
    check("same_edge_out", 64'(out_port), 64'h37);
    check("same_edge_seg_old", 64'(seg_n), 64'(model_seg(24'h11, 6'h0, 6'h2, 1'b1)));
    sb_q.push_back(model_seg(24'h37, 6'h0, 6'h2, 1'b0));
    tick();
    sb_check("same_edge_seg_new");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
